// File: rtl/board_commit_engine.sv
// Playfield commit engine: stamps the live piece into the board, then scans
// bottom-up and collapses full rows one at a time. view_out overlays the live piece.
module board_commit_engine #(
  parameter int ROWS      = 20,
  parameter int COLS      = 10,
  parameter int CW        = 4,
  parameter int CELL_LOG2 = 4,
  parameter int X0        = 250,
  parameter int Y0        = 100
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      clear_board,
  input  logic [9:0]                piece_x,
  input  logic [9:0]                piece_y,
  input  logic [11:0]               piece_dx,
  input  logic [11:0]               piece_dy,
  input  logic [CW-1:0]             piece_color,
  input  logic                      piece_show,
  input  logic                      commit_valid,
  output logic                      busy,
  output logic                      done,
  output logic [2:0]                lines,
  output logic [15:0]               total_lines,
  output logic                      top_out,
  output logic                      oob_err,
  output logic [ROWS*COLS*CW-1:0]   map_out,
  output logic [ROWS*COLS*CW-1:0]   view_out
);

  localparam int N  = ROWS*COLS*CW;
  localparam int RB = COLS*CW;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef logic signed [10:0] coord_t;
  typedef enum logic [2:0] {IDLE, STAMP, SCAN, SHIFT, DONE} state_t;

  localparam coord_t X0S   = coord_t'(X0);
  localparam coord_t Y0S   = coord_t'(Y0);
  localparam coord_t ROWSS = coord_t'(ROWS);
  localparam coord_t COLSS = coord_t'(COLS);

  function automatic logic in_rng(coord_t r, coord_t c);
    return !r[10] && (r < ROWSS) && !c[10] && (c < COLSS);
  endfunction

  function automatic int cbase(coord_t r, coord_t c);
    return (int'(r) * COLS + int'(c)) * CW;
  endfunction

  state_t          state_q, state_d;
  logic [N-1:0]    map_q, map_d, view_q, view_d;
  logic            done_q, done_d, top_q, top_d, oob_q, oob_d;
  logic [2:0]      lines_q, lines_d, cnt_q, cnt_d;
  logic [15:0]     total_q, total_d;
  logic [RW-1:0]   r_q, r_d;
  logic [CW-1:0]   color_q, color_d, col_eff;
  coord_t          row_q [4], row_d [4], col_q [4], col_d [4];
  coord_t          lrow [4], lcol [4];
  coord_t          dx_pix, dy_pix, ax, ay;
  logic            row_full;

  // Live piece cells, shared by commit latch and overlay
  always_comb begin
    dx_pix  = $signed({1'b0, piece_x}) - X0S;
    dy_pix  = $signed({1'b0, piece_y}) - Y0S;
    ax      = dx_pix >>> CELL_LOG2;
    ay      = dy_pix >>> CELL_LOG2;
    col_eff = (piece_color == '0) ? CW'(1) : piece_color;
    for (int i = 0; i < 4; i++) begin
      lrow[i] = ay + coord_t'($signed(piece_dy[3*i +: 3]));
      lcol[i] = ax + coord_t'($signed(piece_dx[3*i +: 3]));
    end
  end

  always_comb begin
    row_full = 1'b1;
    for (int c = 0; c < COLS; c++)
      if (map_q[(int'(r_q)*COLS + c)*CW +: CW] == '0) row_full = 1'b0;
  end

  always_comb begin
    view_d = map_q;
    if (piece_show)
      for (int i = 0; i < 4; i++)
        if (in_rng(lrow[i], lcol[i])) view_d[cbase(lrow[i], lcol[i]) +: CW] = col_eff;
  end

  always_comb begin
    state_d = state_q;
    map_d   = map_q;
    done_d  = 1'b0;
    lines_d = lines_q;
    total_d = total_q;
    top_d   = top_q;
    oob_d   = oob_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    color_d = color_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      IDLE: if (commit_valid) begin
        row_d   = lrow;
        col_d   = lcol;
        color_d = col_eff;
        state_d = STAMP;
      end
      STAMP: begin
        for (int i = 0; i < 4; i++) begin
          if (row_q[i][10]) top_d = 1'b1;
          if (col_q[i][10] || col_q[i] >= COLSS || row_q[i] >= ROWSS) oob_d = 1'b1;
          if (in_rng(row_q[i], col_q[i])) map_d[cbase(row_q[i], col_q[i]) +: CW] = color_q;
        end
        r_d     = RW'(ROWS-1);
        cnt_d   = '0;
        state_d = SCAN;
      end
      SCAN: begin
        if (row_full)        state_d = SHIFT;
        else if (r_q == '0)  state_d = DONE;
        else                 r_d = r_q - RW'(1);
      end
      SHIFT: begin
        // Rescan the same r: the row dropped into it may also be full
        for (int rr = 1; rr < ROWS; rr++)
          if (rr <= int'(r_q)) map_d[rr*RB +: RB] = map_q[(rr-1)*RB +: RB];
        map_d[RB-1:0] = '0;
        if (cnt_q != 3'd7)       cnt_d   = cnt_q + 3'd1;
        if (total_q != 16'hFFFF) total_d = total_q + 16'd1;
        state_d = SCAN;
      end
      DONE: begin
        done_d  = 1'b1;
        lines_d = cnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clear_board) begin
      state_d = IDLE;
      map_d   = '0;
      total_d = '0;
      top_d   = 1'b0;
      oob_d   = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      map_q   <= '0;
      view_q  <= '0;
      done_q  <= 1'b0;
      lines_q <= '0;
      total_q <= '0;
      top_q   <= 1'b0;
      oob_q   <= 1'b0;
      r_q     <= '0;
      cnt_q   <= '0;
      color_q <= '0;
      for (int i = 0; i < 4; i++) begin
        row_q[i] <= '0;
        col_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      map_q   <= map_d;
      view_q  <= view_d;
      done_q  <= done_d;
      lines_q <= lines_d;
      total_q <= total_d;
      top_q   <= top_d;
      oob_q   <= oob_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      color_q <= color_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign lines       = lines_q;
  assign total_lines = total_q;
  assign top_out     = top_q;
  assign oob_err     = oob_q;
  assign map_out     = map_q;
  assign view_out    = view_q;

endmodule

// File: tb/tb_board_commit_engine.sv
// Directed bench for board_commit_engine: commits, row clears, flags, overlay,
// held commit requests, clear and reset aborts.
module tb_board_commit_engine;
  localparam int ROWS = 20, COLS = 10, CW = 4;

  logic Clk = 1'b0, Reset_n = 1'b0, clear_board = 1'b0;
  logic [9:0] piece_x = '0, piece_y = '0;
  logic [11:0] piece_dx = '0, piece_dy = '0;
  logic [CW-1:0] piece_color = '0;
  logic piece_show = 1'b0, commit_valid = 1'b0;
  logic busy, done, top_out, oob_err;
  logic [2:0] lines;
  logic [15:0] total_lines;
  logic [ROWS*COLS*CW-1:0] map_out, view_out;

  int checks = 0, failures = 0;

  board_commit_engine dut (
    .Clk(Clk), .Reset_n(Reset_n), .clear_board(clear_board),
    .piece_x(piece_x), .piece_y(piece_y), .piece_dx(piece_dx), .piece_dy(piece_dy),
    .piece_color(piece_color), .piece_show(piece_show), .commit_valid(commit_valid),
    .busy(busy), .done(done), .lines(lines), .total_lines(total_lines),
    .top_out(top_out), .oob_err(oob_err), .map_out(map_out), .view_out(view_out)
  );

  always #5 Clk = ~Clk;

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] mcell(int r, int c);
    return map_out[(r*COLS + c)*CW +: CW];
  endfunction

  function automatic logic [3:0] vcell(int r, int c);
    return view_out[(r*COLS + c)*CW +: CW];
  endfunction

  // block 0 offset is a, block 3 is d
  function automatic logic [11:0] off4(int a, int b, int c, int d);
    return {d[2:0], c[2:0], b[2:0], a[2:0]};
  endfunction

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic set_piece(input int col, input int row, input logic [11:0] dx,
                           input logic [11:0] dy, input logic [3:0] c);
    piece_x = 10'(250 + 16*col);
    piece_y = 10'(100 + 16*row);
    piece_dx = dx;
    piece_dy = dy;
    piece_color = c;
  endtask

  task automatic commit(input int col, input int row, input logic [11:0] dx,
                        input logic [11:0] dy, input logic [3:0] c, output int lat);
    set_piece(col, row, dx, dy, c);
    commit_valid = 1'b1;
    tick();
    commit_valid = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin tick(); lat++; end
  endtask

  task automatic do_clear();
    clear_board = 1'b1;
    tick();
    clear_board = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    tick(); tick();
    checks++; if ({busy, done, top_out, oob_err} !== 4'b0) begin failures++;
      $display("FAIL reset_flags got=%b exp=0000", {busy, done, top_out, oob_err}); end
    checks++; if (lines !== 3'd0 || total_lines !== 16'd0) begin failures++;
      $display("FAIL reset_counts got=%0d/%0d exp=0/0", lines, total_lines); end
    checks++; if (map_out !== '0 || view_out !== '0) begin failures++;
      $display("FAIL reset_board got=nonzero exp=0"); end
    Reset_n = 1'b1;
    tick();
  endtask

  task automatic test_o_piece();
    int lat;
    commit(0, 19, off4(0, 1, 0, 1), off4(0, 0, -1, -1), 4'd2, lat);
    checks++; if (lat !== 22) begin failures++; $display("FAIL o_latency got=%0d exp=22", lat); end
    checks++; if ({mcell(19,0), mcell(19,1), mcell(18,0), mcell(18,1)} !== 16'h2222) begin failures++;
      $display("FAIL o_cells got=%h exp=2222", {mcell(19,0), mcell(19,1), mcell(18,0), mcell(18,1)}); end
    checks++; if (mcell(17,0) !== 4'd0 || mcell(19,2) !== 4'd0) begin failures++;
      $display("FAIL o_neighbours got=%h%h exp=00", mcell(17,0), mcell(19,2)); end
    checks++; if (lines !== 3'd0 || busy !== 1'b0) begin failures++;
      $display("FAIL o_lines_busy got=%0d/%b exp=0/0", lines, busy); end
  endtask

  task automatic test_line_clear();
    int lat;
    do_clear();
    commit(4, 19, off4(0, 1, 2, 3), 12'd0, 4'd3, lat);
    commit(8, 19, off4(0, 1, 0, 1), off4(0, 0, -1, -1), 4'd4, lat);
    commit(0, 19, off4(0, 1, 2, 3), 12'd0, 4'd5, lat);
    checks++; if (lat !== 24) begin failures++; $display("FAIL clr1_latency got=%0d exp=24", lat); end
    checks++; if (lines !== 3'd1 || total_lines !== 16'd1) begin failures++;
      $display("FAIL clr1_counts got=%0d/%0d exp=1/1", lines, total_lines); end
    checks++; if ({mcell(19,8), mcell(19,9), mcell(19,0), mcell(19,4)} !== 16'h4400) begin failures++;
      $display("FAIL clr1_row19 got=%h exp=4400", {mcell(19,8), mcell(19,9), mcell(19,0), mcell(19,4)}); end
    checks++; if (mcell(18,8) !== 4'd0 || mcell(0,0) !== 4'd0) begin failures++;
      $display("FAIL clr1_upper got=%h%h exp=00", mcell(18,8), mcell(0,0)); end
  endtask

  task automatic test_reset_mid();
    int dn = 0;
    set_piece(0, 19, 12'd0, 12'd0, 4'd6);
    commit_valid = 1'b1;
    tick();
    commit_valid = 1'b0;
    repeat (5) tick();
    Reset_n = 1'b0;
    commit_valid = 1'b1;
    tick();
    checks++; if ({busy, done, top_out, oob_err} !== 4'b0 || lines !== 3'd0 || total_lines !== 16'd0) begin
      failures++; $display("FAIL rstmid_outputs got=%b/%0d/%0d exp=0000/0/0",
                            {busy, done, top_out, oob_err}, lines, total_lines); end
    checks++; if (map_out !== '0 || view_out !== '0) begin failures++;
      $display("FAIL rstmid_board got=nonzero exp=0"); end
    Reset_n = 1'b1;
    commit_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin tick(); if (done === 1'b1) dn++; end
    checks++; if (dn !== 0 || busy !== 1'b0) begin failures++;
      $display("FAIL rstmid_nodone got=%0d/%b exp=0/0", dn, busy); end
  endtask

  task automatic test_tetris();
    int lat;
    do_clear();
    for (int r = 16; r < 20; r++) begin
      commit(0, r, off4(0, 1, 2, 3), 12'd0, 4'd2, lat);
      commit(4, r, off4(0, 1, 2, 3), 12'd0, 4'd3, lat);
    end
    commit(8, 16, 12'd0, off4(0, 1, 2, 3), 4'd4, lat);
    commit(0, 12, 12'd0, off4(0, 1, 2, 3), 4'd6, lat);
    commit(5, 12, off4(0, 1, 2, 3), off4(0, 1, 2, 3), 4'd9, lat);
    commit(9, 16, 12'd0, off4(0, 1, 2, 3), 4'd1, lat);
    checks++; if (lat !== 30) begin failures++; $display("FAIL tet_latency got=%0d exp=30", lat); end
    checks++; if (lines !== 3'd4 || total_lines !== 16'd4) begin failures++;
      $display("FAIL tet_counts got=%0d/%0d exp=4/4", lines, total_lines); end
    checks++; if ({mcell(16,0), mcell(17,0), mcell(18,0), mcell(19,0)} !== 16'h6666) begin failures++;
      $display("FAIL tet_col0 got=%h exp=6666", {mcell(16,0), mcell(17,0), mcell(18,0), mcell(19,0)}); end
    checks++; if ({mcell(16,5), mcell(17,6), mcell(18,7), mcell(19,8)} !== 16'h9999) begin failures++;
      $display("FAIL tet_diag got=%h exp=9999", {mcell(16,5), mcell(17,6), mcell(18,7), mcell(19,8)}); end
    checks++; if (mcell(19,1) !== 4'd0 || mcell(16,9) !== 4'd0 || map_out[16*COLS*CW-1:0] !== '0) begin
      failures++; $display("FAIL tet_empty got=%h%h exp=00", mcell(19,1), mcell(16,9)); end
  endtask

  task automatic test_top_oob();
    int lat;
    do_clear();
    commit(3, -1, 12'd0, off4(0, 1, 2, 3), 4'd0, lat);
    checks++; if (top_out !== 1'b1 || oob_err !== 1'b0 || lat !== 22) begin failures++;
      $display("FAIL top_flags got=%b%b/%0d exp=10/22", top_out, oob_err, lat); end
    checks++; if ({mcell(0,3), mcell(1,3), mcell(2,3)} !== 12'h111) begin failures++;
      $display("FAIL top_cells got=%h exp=111", {mcell(0,3), mcell(1,3), mcell(2,3)}); end
    commit(9, 5, off4(1, 0, 0, 0), 12'd0, 4'd5, lat);
    checks++; if (oob_err !== 1'b1 || top_out !== 1'b1 || lat !== 22) begin failures++;
      $display("FAIL oob_flags got=%b%b/%0d exp=11/22", top_out, oob_err, lat); end
    checks++; if (mcell(5,9) !== 4'd5 || mcell(6,0) !== 4'd0) begin failures++;
      $display("FAIL oob_cells got=%h%h exp=50", mcell(5,9), mcell(6,0)); end
    do_clear();
    checks++; if (top_out !== 1'b0 || oob_err !== 1'b0 || map_out !== '0 || total_lines !== 16'd0) begin
      failures++; $display("FAIL flags_clear got=%b%b/%0d exp=00/0", top_out, oob_err, total_lines); end
  endtask

  task automatic test_view();
    int lat;
    commit(0, 19, 12'd0, 12'd0, 4'd2, lat);
    tick();
    set_piece(0, 19, off4(-1, 1, 0, 0), 12'd0, 4'd7);
    piece_show = 1'b1;
    #1;
    checks++; if (vcell(19,1) !== 4'd0 || vcell(19,0) !== 4'd2) begin failures++;
      $display("FAIL view_early got=%h%h exp=02", vcell(19,1), vcell(19,0)); end
    tick();
    checks++; if (vcell(19,0) !== 4'd7 || vcell(19,1) !== 4'd7 || mcell(19,0) !== 4'd2) begin failures++;
      $display("FAIL view_overlay got=%h%h/%h exp=77/2", vcell(19,0), vcell(19,1), mcell(19,0)); end
    checks++; if (vcell(18,9) !== 4'd0) begin failures++;
      $display("FAIL view_offboard got=%h exp=0", vcell(18,9)); end
    piece_show = 1'b0;
    tick();
    checks++; if (vcell(19,0) !== 4'd2 || vcell(19,1) !== 4'd0) begin failures++;
      $display("FAIL view_hide got=%h%h exp=20", vcell(19,0), vcell(19,1)); end
  endtask

  task automatic test_back_to_back();
    int rises = 0, dones = 0, done_at = -1, rise2 = -1, lat = 0;
    logic prev;
    do_clear();
    set_piece(2, 19, 12'd0, 12'd0, 4'd3);
    prev = busy;
    commit_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (busy && !prev) begin rises++; if (rises == 2) rise2 = i; end
      if (done === 1'b1) begin dones++; done_at = i; end
      prev = busy;
    end
    commit_valid = 1'b0;
    checks++; if (rises !== 2 || dones !== 1) begin failures++;
      $display("FAIL b2b_counts got=%0d/%0d exp=2/1", rises, dones); end
    checks++; if (done_at !== 22 || rise2 !== 23) begin failures++;
      $display("FAIL b2b_timing got=%0d/%0d exp=22/23", done_at, rise2); end
    while (done !== 1'b1 && lat < 100) begin tick(); lat++; end
    checks++; if (lat !== 16 || mcell(19,2) !== 4'd3 || total_lines !== 16'd0) begin failures++;
      $display("FAIL b2b_second got=%0d/%h/%0d exp=16/3/0", lat, mcell(19,2), total_lines); end
  endtask

  task automatic test_clear_abort();
    int lat, dn = 0;
    do_clear();
    commit(0, 19, off4(0, 1, 2, 3), 12'd0, 4'd3, lat);
    commit(4, 19, off4(0, 1, 2, 3), 12'd0, 4'd3, lat);
    set_piece(8, 19, off4(0, 1, 0, 1), 12'd0, 4'd4);
    commit_valid = 1'b1;
    tick();
    commit_valid = 1'b0;
    tick(); tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_busy got=%b exp=1", busy); end
    clear_board = 1'b1;
    tick();
    clear_board = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || map_out !== '0 || total_lines !== 16'd0) begin
      failures++; $display("FAIL abort_state got=%b%b/%0d exp=00/0", busy, done, total_lines); end
    for (int i = 0; i < 30; i++) begin tick(); if (done === 1'b1) dn++; end
    checks++; if (dn !== 0 || lines !== 3'd0) begin failures++;
      $display("FAIL abort_nodone got=%0d/%0d exp=0/0", dn, lines); end
  endtask

  initial begin
    test_reset();
    test_o_piece();
    test_line_clear();
    test_reset_mid();
    test_tetris();
    test_top_oob();
    test_view();
    test_back_to_back();
    test_clear_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/board_commit_engine.md
BOARD_COMMIT_ENGINE -- requirements
Module: board_commit_engine

Interface
REQ-001 Parameters SHALL be: ROWS, default 20, board rows; COLS, default 10, board columns; CW, default 4, cell colour width; CELL_LOG2, default 4, log2 of cell size in pixels; X0, default 250, board left pixel; Y0, default 100, board top pixel.
REQ-002 Clk  in  1  the single clock; all state on rising edge.
REQ-003 Reset_n  in  1  synchronous, active-low reset.
REQ-004 clear_board  in  1  one-cycle request to empty the board.
REQ-005 piece_x, piece_y  in  10 each  anchor pixel coordinates of the live piece.
REQ-006 piece_dx, piece_dy  in  12 each  four 3-bit two's-complement cell offsets; block i is at bits [3i+2:3i].
REQ-007 piece_color  in  CW  colour code of the live piece; 0 is illegal and is treated as 1.
REQ-008 piece_show  in  1  live piece is overlaid on view_out.
REQ-009 commit_valid  in  1  request to stamp the live piece into the board; accepted only when busy=0.
REQ-010 busy  out  1  commit sequence in progress.
REQ-011 done  out  1  one-cycle pulse when a commit sequence ends.
REQ-012 lines  out  3  rows cleared by the last commit (0..4); held until the next done.
REQ-013 total_lines  out  16  saturating count of rows cleared since reset or clear.
REQ-014 top_out, oob_err  out  1 each  sticky flags: block above the board; block outside columns or below the bottom.
REQ-015 map_out  out  ROWS*COLS*CW  committed board, row-major, row 0 at the top, cell [r][c] at offset (r*COLS+c)*CW.
REQ-016 view_out  out  ROWS*COLS*CW  map_out with the live piece overlaid, registered.

Function
REQ-017 Anchor cell SHALL be: ax=(piece_x-X0)>>>CELL_LOG2 and ay=(piece_y-Y0)>>>CELL_LOG2, both 11-bit signed; block i cell=(ay+dy_i, ax+dx_i).
REQ-018 The FSM SHALL have states IDLE, STAMP, SCAN, SHIFT and DONE; busy=1 in every state except IDLE.
REQ-019 IDLE: when commit_valid=1, the block SHALL latch the four block cells and the colour, then go to STAMP next cycle; commit_valid during busy SHALL be ignored and not queued.
REQ-020 STAMP (1 cycle): each in-range block SHALL write its colour into map_out, overwriting the cell; row<0 SHALL set top_out; col<0, col>=COLS or row>=ROWS SHALL set oob_err; out-of-range blocks are dropped. Next state is SCAN with r=ROWS-1 and the per-commit count=0.
REQ-021 SCAN (1 row/cycle): when all COLS cells of row r are non-zero, go to SHIFT; else when r=0, go to DONE; else r decrements by 1.
REQ-022 SHIFT (1 cycle): rows 1..r SHALL take the content of the row above; row 0 SHALL be zeroed; count and total_lines increment; return to SCAN with the same r.
REQ-023 DONE (1 cycle): done=1 and lines=count, then go to IDLE.
REQ-024 Latency from the accept edge to done SHALL be ROWS+2+2k cycles, with k = rows cleared.
REQ-025 view_out SHALL update one cycle after its inputs; overlay cells are in-range live blocks when piece_show=1; the live colour wins over board content; in-range blocks are drawn even when other blocks are out of range.
REQ-026 clear_board SHALL win over everything in any state: next cycle board=0, total_lines=0, top_out=oob_err=0, FSM=IDLE, no done pulse; lines is held.
REQ-027 total_lines SHALL saturate at 16'hFFFF.
REQ-028 Duplicate block cells SHALL write the same colour once; this is not an error.

Reset
REQ-029 When Reset_n=0 at a clock edge, the block SHALL set FSM=IDLE, board and view_out to all zero, and busy, done, lines, total_lines, top_out and oob_err to 0.
REQ-030 Reset SHALL override clear_board and commit_valid; reset mid-sequence SHALL abort it with no done pulse.

Verification
REQ-031 Empty board; O piece offsets (0,0),(1,0),(0,-1),(1,-1), anchor pixel (250,404), colour 2, commit -> cells [19][0],[19][1],[18][0],[18][1]=2; done 22 cycles after accept; lines=0.
REQ-032 Row 19 pre-filled except cols 0-3; I piece horizontal at row 19 cols 0-3, commit -> row 19 takes old row 18; row 0=0; lines=1; total_lines=1; done at 24 cycles.
REQ-033 Rows 16-19 each full except col 9; vertical I piece into col 9, commit -> all four rows cleared; lines=4; board rows 16-19 take old rows 12-15.
REQ-034 Anchor row -1 with offset dy=0, commit -> that block is dropped; top_out=1 and stays 1 until clear_board.
REQ-035 commit_valid held high for 30 cycles -> exactly one commit per IDLE visit; the second commit is accepted the cycle after done.
REQ-036 clear_board asserted during SHIFT -> next cycle board=0, busy=0, no done pulse; Reset_n=0 mid-SCAN -> all outputs 0.
